// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and default widths for the multi-cycle memory access controller.
package mem_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_ADDR_WIDTH  = 16;
   localparam int DEF_MEM_LATENCY = 4;
   localparam int CNT_WIDTH       = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      XFER_LO = 2'd2,
      DONE    = 2'd3
   } mem_state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DM = 1'b1
   } port_sel_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter; req[0] is fetch, req[1] is data.
module mem_rr_arbiter
   import mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant_valid,
   output port_sel_t  grant_sel
);

   port_sel_t r_last;

   // Grant selection: a tie goes to the port that did not win last time.
   always_comb begin
      grant_valid = |req;
      grant_sel   = PORT_IF;
      case (req)
         2'b01:   grant_sel = PORT_IF;
         2'b10:   grant_sel = PORT_DM;
         2'b11: begin
            if (r_last == PORT_IF) begin
               grant_sel = PORT_DM;
            end else begin
               grant_sel = PORT_IF;
            end
         end
         default: grant_sel = PORT_IF;
      endcase
   end

   // Last-granted pointer, moved only when the grant is actually taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= PORT_IF;
      end else if (advance) begin
         r_last <= grant_sel;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and data ports onto a single-port word memory with a fixed
// address hold latency; 32-bit data accesses use two words (high at addr, low at addr+1).
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_done,
   input  logic                    dm_req,
   input  logic                    dm_we,
   input  logic [ADDR_WIDTH-1:0]   dm_addr,
   input  logic [2*DATA_WIDTH-1:0] dm_wdata,
   output logic [2*DATA_WIDTH-1:0] dm_rdata,
   output logic                    dm_done,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH-1:0]   mem_data_write_high,
   output logic [DATA_WIDTH-1:0]   mem_data_write_low,
   output logic                    mem_we,
   input  logic [DATA_WIDTH-1:0]   mem_data_read
);

   localparam logic [CNT_WIDTH-1:0] LAT_LAST = CNT_WIDTH'(MEM_LATENCY - 1);
   localparam logic [CNT_WIDTH-1:0] LAT_PRE  = CNT_WIDTH'(MEM_LATENCY - 2);
   localparam logic                 LAT_ONE  = 1'(MEM_LATENCY == 1);

   mem_state_t                r_state;
   mem_state_t                w_next_state;
   logic [CNT_WIDTH-1:0]      r_cnt;
   port_sel_t                 r_port;
   logic                      r_we;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [ADDR_WIDTH-1:0]     r_mem_address;
   logic [DATA_WIDTH-1:0]     r_wd_hi;
   logic [DATA_WIDTH-1:0]     r_wd_lo;
   logic [DATA_WIDTH-1:0]     r_hi;
   logic [DATA_WIDTH-1:0]     r_if_rdata;
   logic [2*DATA_WIDTH-1:0]   r_dm_rdata;
   logic                      r_mem_we;
   logic                      r_if_done;
   logic                      r_dm_done;

   logic                      w_grant_valid;
   port_sel_t                 w_grant_sel;
   logic                      w_advance;
   logic                      w_wait_last;
   logic                      w_we_next;
   logic                      w_grant_we;
   logic [ADDR_WIDTH-1:0]     w_grant_addr;
   logic [ADDR_WIDTH-1:0]     w_addr_inc;

   mem_rr_arbiter u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         ({dm_req, if_req}),
      .advance     (w_advance),
      .grant_valid (w_grant_valid),
      .grant_sel   (w_grant_sel)
   );

   assign w_wait_last = (r_state == WAIT) && (r_cnt == LAT_LAST);
   assign w_addr_inc  = r_addr + ADDR_WIDTH'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) begin
               w_next_state = WAIT;
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT: begin
            if (!w_wait_last) begin
               w_next_state = WAIT;
            end else if ((r_port == PORT_DM) && !r_we) begin
               w_next_state = XFER_LO;
            end else begin
               w_next_state = DONE;
            end
         end
         XFER_LO: w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Output decode; the write strobe is looked ahead one cycle so mem_we stays registered.
   always_comb begin
      w_advance = 1'b0;
      w_we_next = 1'b0;
      if (w_grant_sel == PORT_DM) begin
         w_grant_we   = dm_we;
         w_grant_addr = dm_addr;
      end else begin
         w_grant_we   = 1'b0;
         w_grant_addr = if_addr;
      end
      case (r_state)
         IDLE: begin
            w_advance = w_grant_valid;
            w_we_next = w_grant_valid && w_grant_we && LAT_ONE;
         end
         WAIT: begin
            w_we_next = !LAT_ONE && (r_cnt == LAT_PRE) && r_we;
         end
         default: begin
            w_advance = 1'b0;
            w_we_next = 1'b0;
         end
      endcase
   end

   // Latency counter, request latches, memory drive and read-data capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_port        <= PORT_IF;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_mem_address <= '0;
         r_wd_hi       <= '0;
         r_wd_lo       <= '0;
         r_hi          <= '0;
         r_if_rdata    <= '0;
         r_dm_rdata    <= '0;
         r_mem_we      <= 1'b0;
         r_if_done     <= 1'b0;
         r_dm_done     <= 1'b0;
      end else begin
         r_mem_we  <= w_we_next;
         r_if_done <= 1'b0;
         r_dm_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (w_grant_valid) begin
                  r_port        <= w_grant_sel;
                  r_we          <= w_grant_we;
                  r_addr        <= w_grant_addr;
                  r_mem_address <= w_grant_addr;
                  if (w_grant_sel == PORT_DM) begin
                     r_wd_hi <= dm_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
                     r_wd_lo <= dm_wdata[DATA_WIDTH-1:0];
                  end
               end
            end
            WAIT: begin
               if (!w_wait_last) begin
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
               end else begin
                  r_cnt <= '0;
                  if (r_port == PORT_IF) begin
                     r_if_rdata <= mem_data_read;
                     r_if_done  <= 1'b1;
                  end else if (r_we) begin
                     r_dm_done <= 1'b1;
                  end else begin
                     // High word parked until the low word arrives so dm_rdata only moves with dm_done.
                     r_hi          <= mem_data_read;
                     r_mem_address <= w_addr_inc;
                  end
               end
            end
            XFER_LO: begin
               r_dm_rdata <= {r_hi, mem_data_read};
               r_dm_done  <= 1'b1;
            end
            DONE: begin
               r_cnt <= '0;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign if_rdata            = r_if_rdata;
   assign if_done             = r_if_done;
   assign dm_rdata            = r_dm_rdata;
   assign dm_done             = r_dm_done;
   assign mem_address         = r_mem_address;
   assign mem_data_write_high = r_wd_hi;
   assign mem_data_write_low  = r_wd_lo;
   assign mem_we              = r_mem_we;

endmodule
